ps2_key_ctrl: RTL and testbench

PS/2 keyboard receiver and game-key decoder. It sits directly upstream of the game-object logic and the top-level score reset, and runs in the 25 MHz VGA clock domain. It deserialises PS/2 frames, validates them, and tracks make and break codes. It issues single-cycle fly/start/ret pulses, one per physical key press, ignoring typematic repeats.

---
 rtl/ps2_key_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_ps2_key_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl.sv
// PS/2 keyboard receiver with make/break tracking that emits single-cycle fly/start/ret pulses.
// Optional frame abort on a stalled PS/2 clock: define PS2_TIMEOUT_EN.
module ps2_key_ctrl #(
    parameter int          FILTER_LEN  = 8,
    parameter int          TIMEOUT_CYC = 25000,
    parameter logic [7:0]  KEY_FLY     = 8'h29,
    parameter logic [7:0]  KEY_START   = 8'h5A,
    parameter logic [7:0]  KEY_RET     = 8'h2D
) (
    input  logic       clk25,
    input  logic       clr,
    input  logic       PS2C,
    input  logic       PS2D,
    output logic       fly,
    output logic       start,
    output logic       ret,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       frame_err
);

    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} dec_state_e;

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("ps2_key_ctrl: TIMEOUT_CYC must be at least 2");
    end

    logic                  c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    logic [FILTER_LEN-1:0] filt_sr_q, filt_sr_d;
    logic                  filt_clk_q, filt_clk_d;
    logic                  fall;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [8:0]            shift_q, shift_d;
    logic [7:0]            scan_code_q, scan_code_d;
    logic                  code_valid_q, code_valid_d;
    logic                  frame_err_q, frame_err_d;
    dec_state_e            state_q, state_d;
    logic [2:0]            held_q, held_d;
    logic [2:0]            key_hit;
    logic                  fly_q, fly_d, start_q, start_d, ret_q, ret_d;
`ifdef PS2_TIMEOUT_EN
    logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        filt_sr_d  = {filt_sr_q[FILTER_LEN-2:0], c_s2_q};
        filt_clk_d = filt_clk_q;
        if (&filt_sr_q)
            filt_clk_d = 1'b1;
        else if (~|filt_sr_q)
            filt_clk_d = 1'b0;
        fall = filt_clk_q & ~filt_clk_d;
    end

    // Frame assembly: D0..D7 then parity shift in from the top, so D0 lands in bit 0.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        scan_code_d  = scan_code_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
`ifdef PS2_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
`endif
        if (fall) begin
            if (bit_cnt_q == 4'd0) begin
                if (!d_s2_q)
                    bit_cnt_d = 4'd1;
            end else if (bit_cnt_q == 4'd10) begin
                if (d_s2_q && (^shift_q)) begin
                    scan_code_d  = shift_q[7:0];
                    code_valid_d = 1'b1;
                end else begin
                    frame_err_d = 1'b1;
                end
                bit_cnt_d = 4'd0;
            end else begin
                shift_d   = {d_s2_q, shift_q[8:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
`ifdef PS2_TIMEOUT_EN
        if (fall) begin
            to_cnt_d = '0;
        end else if (bit_cnt_q != 4'd0) begin
            if (to_cnt_q == TO_W'(TIMEOUT_CYC)) begin
                bit_cnt_d   = 4'd0;
                frame_err_d = 1'b1;
                to_cnt_d    = '0;
            end else begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end else begin
            to_cnt_d = '0;
        end
`endif
    end

    // Decoder consumes the registered byte, so game pulses trail code_valid by one cycle.
    always_comb begin
        state_d = state_q;
        held_d  = held_q;
        fly_d   = 1'b0;
        start_d = 1'b0;
        ret_d   = 1'b0;
        key_hit = {scan_code_q == KEY_RET, scan_code_q == KEY_START, scan_code_q == KEY_FLY};
        if (code_valid_q) begin
            case (state_q)
                IDLE: begin
                    if (scan_code_q == 8'hF0) begin
                        state_d = BRK;
                    end else if (scan_code_q == 8'hE0) begin
                        state_d = EXT;
                    end else begin
                        fly_d   = key_hit[0] & ~held_q[0];
                        start_d = key_hit[1] & ~held_q[1];
                        ret_d   = key_hit[2] & ~held_q[2];
                        held_d  = held_q | key_hit;
                    end
                end
                BRK: begin
                    held_d  = held_q & ~key_hit;
                    state_d = IDLE;
                end
                EXT:     state_d = (scan_code_q == 8'hF0) ? EXT_BRK : IDLE;
                EXT_BRK: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk25 or posedge clr) begin
        if (clr) begin
            c_s1_q       <= 1'b1;
            c_s2_q       <= 1'b1;
            d_s1_q       <= 1'b1;
            d_s2_q       <= 1'b1;
            filt_sr_q    <= '1;
            filt_clk_q   <= 1'b1;
            bit_cnt_q    <= 4'd0;
            shift_q      <= '0;
            scan_code_q  <= 8'h00;
            code_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            state_q      <= IDLE;
            held_q       <= 3'b000;
            fly_q        <= 1'b0;
            start_q      <= 1'b0;
            ret_q        <= 1'b0;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q     <= '0;
`endif
        end else begin
            c_s1_q       <= PS2C;
            c_s2_q       <= c_s1_q;
            d_s1_q       <= PS2D;
            d_s2_q       <= d_s1_q;
            filt_sr_q    <= filt_sr_d;
            filt_clk_q   <= filt_clk_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            scan_code_q  <= scan_code_d;
            code_valid_q <= code_valid_d;
            frame_err_q  <= frame_err_d;
            state_q      <= state_d;
            held_q       <= held_d;
            fly_q        <= fly_d;
            start_q      <= start_d;
            ret_q        <= ret_d;
`ifdef PS2_TIMEOUT_EN
            to_cnt_q     <= to_cnt_d;
`endif
        end
    end

    assign fly        = fly_q;
    assign start      = start_q;
    assign ret        = ret_q;
    assign scan_code  = scan_code_q;
    assign code_valid = code_valid_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: per-frame vector table plus reset, glitch and partial-frame sequences.
module tb_ps2_key_ctrl;

    localparam int H = 50;

    logic       clk25 = 1'b0;
    logic       clr   = 1'b1;
    logic       PS2C  = 1'b1;
    logic       PS2D  = 1'b1;
    logic       fly, start, ret, code_valid, frame_err;
    logic [7:0] scan_code;

    ps2_key_ctrl dut (
        .clk25(clk25), .clr(clr), .PS2C(PS2C), .PS2D(PS2D),
        .fly(fly), .start(start), .ret(ret),
        .scan_code(scan_code), .code_valid(code_valid), .frame_err(frame_err)
    );

    always #20 clk25 = ~clk25;

    int n_cmp = 0;
    int n_bad = 0;
    int c_fly = 0, c_start = 0, c_ret = 0, c_cv = 0, c_err = 0;
    logic       prev_cv = 1'b0;
    logic [7:0] prev_sc = 8'h00;

    typedef struct {
        logic [7:0] code;
        logic       bad;
        int         fly, start, ret, cv, err;
        logic [7:0] sc;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Game pulses must follow a code_valid carrying their key by exactly one cycle.
    always @(negedge clk25) begin
        if (fly) begin
            c_fly++;
            check("fly_latency", {23'd0, prev_cv, prev_sc}, {23'd0, 1'b1, 8'h29});
        end
        if (start) begin
            c_start++;
            check("start_latency", {23'd0, prev_cv, prev_sc}, {23'd0, 1'b1, 8'h5A});
        end
        if (ret) begin
            c_ret++;
            check("ret_latency", {23'd0, prev_cv, prev_sc}, {23'd0, 1'b1, 8'h2D});
        end
        if (code_valid) c_cv++;
        if (frame_err)  c_err++;
        prev_cv = code_valid;
        prev_sc = scan_code;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic bad);
        return {1'b1, (~^d) ^ bad, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            PS2D = b[i];
            wait_clk(H);
            PS2C = 1'b0;
            wait_clk(H);
            PS2C = 1'b1;
        end
        PS2D = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic bad);
        send_bits(frame(d, bad), 11);
        wait_clk(H);
    endtask

    task automatic check_frame(input string name, input logic [7:0] d, input logic bad,
                               input int e_fly, input int e_start, input int e_ret,
                               input int e_cv, input int e_err, input logic [7:0] e_sc);
        int f0, s0, r0, v0, x0;
        f0 = c_fly; s0 = c_start; r0 = c_ret; v0 = c_cv; x0 = c_err;
        send_byte(d, bad);
        check({name, ".fly"},   c_fly - f0,   e_fly);
        check({name, ".start"}, c_start - s0, e_start);
        check({name, ".ret"},   c_ret - r0,   e_ret);
        check({name, ".cv"},    c_cv - v0,    e_cv);
        check({name, ".err"},   c_err - x0,   e_err);
        check({name, ".sc"},    int'(scan_code), int'(e_sc));
    endtask

    initial begin
        int v0, x0;
        tbl[0]  = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[1]  = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[2]  = '{8'h29, 1'b0, 1, 0, 0, 1, 0, 8'h29};
        tbl[3]  = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[4]  = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[5]  = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[6]  = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[7]  = '{8'h29, 1'b0, 1, 0, 0, 1, 0, 8'h29};
        tbl[8]  = '{8'h5A, 1'b0, 0, 1, 0, 1, 0, 8'h5A};
        tbl[9]  = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[10] = '{8'h5A, 1'b0, 0, 0, 0, 1, 0, 8'h5A};
        tbl[11] = '{8'h2D, 1'b0, 0, 0, 1, 1, 0, 8'h2D};
        tbl[12] = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[13] = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[14] = '{8'h5A, 1'b1, 0, 0, 0, 0, 1, 8'h29};
        tbl[15] = '{8'hE0, 1'b0, 0, 0, 0, 1, 0, 8'hE0};
        tbl[16] = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[17] = '{8'hE0, 1'b0, 0, 0, 0, 1, 0, 8'hE0};
        tbl[18] = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[19] = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};
        tbl[20] = '{8'h29, 1'b0, 1, 0, 0, 1, 0, 8'h29};
        tbl[21] = '{8'hF0, 1'b0, 0, 0, 0, 1, 0, 8'hF0};
        tbl[22] = '{8'h29, 1'b0, 0, 0, 0, 1, 0, 8'h29};

        // Reset values, then a reset landing mid-frame.
        wait_clk(5);
        @(negedge clk25);
        check("rst.outs", {fly, start, ret, code_valid, frame_err}, 0);
        check("rst.sc", int'(scan_code), 0);
        clr = 1'b0;
        wait_clk(10);
        send_bits(frame(8'h29, 1'b0), 5);
        clr = 1'b1;
        wait_clk(3);
        clr = 1'b0;
        wait_clk(10);
        check("midrst.cv", c_cv, 0);
        check("midrst.err", c_err, 0);
        check("midrst.sc", int'(scan_code), 0);
        check_frame("after_rst", 8'h29, 1'b0, 1, 0, 0, 1, 0, 8'h29);

        for (int i = 0; i < 23; i++)
            check_frame($sformatf("vec%0d", i), tbl[i].code, tbl[i].bad, tbl[i].fly,
                        tbl[i].start, tbl[i].ret, tbl[i].cv, tbl[i].err, tbl[i].sc);

        // Short PS2C lows must never be seen as clock edges.
        v0 = c_cv; x0 = c_err;
        for (int i = 0; i < 6; i++) begin
            PS2D = 1'b0;
            PS2C = 1'b0;
            wait_clk(3);
            PS2C = 1'b1;
            wait_clk(20);
        end
        PS2D = 1'b1;
        wait_clk(30);
        check("glitch.cv", c_cv - v0, 0);
        check("glitch.err", c_err - x0, 0);
        check_frame("post_glitch", 8'h29, 1'b0, 1, 0, 0, 1, 0, 8'h29);

        // Partial frame followed by a stalled clock.
        send_bits(frame(8'h5A, 1'b0), 4);
`ifdef PS2_TIMEOUT_EN
        x0 = c_err;
        wait_clk(24800);
        check("timeout.early", c_err - x0, 0);
        wait_clk(400);
        check("timeout.err", c_err - x0, 1);
        wait_clk(4800);
        check_frame("after_timeout", 8'h5A, 1'b0, 0, 1, 0, 1, 0, 8'h5A);
`else
        wait_clk(2000);
        check_frame("misaligned", 8'h5A, 1'b0, 0, 0, 0, 0, 1, 8'h29);
        clr = 1'b1;
        wait_clk(3);
        clr = 1'b0;
        wait_clk(10);
        check_frame("realigned", 8'h5A, 1'b0, 0, 1, 0, 1, 0, 8'h5A);
`endif

        wait_clk(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
